lane_pack_sequencer: RTL and testbench

LANE_PACK_SEQUENCER -- requirements
Module: lane_pack_sequencer

---
 rtl/lane_pack_sequencer.sv | 105 ++++++++++
 tb/tb_lane_pack_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lane_pack_sequencer.sv
// ============================================================================
//  lane_pack_sequencer -- packs a byte stream into width-bit words with flush
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lane_pack_sequencer #(
   parameter int width = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7:0]                in,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [width-1:0]          out,
   output logic [$clog2(width/8):0]  out_bytes,
   output logic [15:0]               word_count
);

   localparam int LANES  = width / 8;
   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = LANE_W + 1;

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [0:0]        state_q,      state_d;
   logic [LANE_W-1:0] lane_q,       lane_d;
   logic [width-1:0]  out_q,        out_d;
   logic [CNT_W-1:0]  out_bytes_q,  out_bytes_d;
   logic [15:0]       word_count_q, word_count_d;
   logic              accept;

   assign in_ready   = (state_q == FILL) && !reset;
   assign out_valid  = (state_q == HOLD);
   assign out        = out_q;
   assign out_bytes  = out_bytes_q;
   assign word_count = word_count_q;
   assign accept     = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      out_d        = out_q;
      out_bytes_d  = out_bytes_q;
      word_count_d = word_count_q;

      case (state_q)
         FILL: begin
            if (accept) begin
               for (int k = 0; k < LANES; k++) begin
                  if (lane_q == LANE_W'(k)) begin
                     out_d[8*k +: 8] = in;
                  end
               end
               // A flush arriving with a byte closes the word after that byte.
               if (flush || (lane_q == LAST_LANE)) begin
                  state_d     = HOLD;
                  out_bytes_d = {1'b0, lane_q} + CNT_W'(1);
                  lane_d      = '0;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end else if (flush && (lane_q != '0)) begin
               state_d     = HOLD;
               out_bytes_d = {1'b0, lane_q};
               lane_d      = '0;
            end
         end
         default: begin
            // Handoff clears the word so unwritten lanes of the next one read zero.
            if (out_ready) begin
               state_d      = FILL;
               out_d        = '0;
               out_bytes_d  = '0;
               word_count_d = word_count_q + 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= FILL;
         lane_q       <= '0;
         out_q        <= '0;
         out_bytes_q  <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         out_q        <= out_d;
         out_bytes_q  <= out_bytes_d;
         word_count_q <= word_count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lane_pack_sequencer.sv
// ============================================================================
//  tb_lane_pack_sequencer -- vector table, corner sequences and random traffic
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lane_pack_sequencer;

   localparam int W     = 32;
   localparam int LANES = W / 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_byte;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_word;
   logic [2:0]    out_bytes;
   logic [15:0]   word_count;

   lane_pack_sequencer #(.width(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in         (in_byte),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out_word),
      .out_bytes  (out_bytes),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   // Record layout: {in_ready, out_valid, out, out_bytes, word_count}
   typedef struct {
      logic        rst;
      logic        iv;
      logic [7:0]  b;
      logic        fl;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_out;
      logic [2:0]  e_bytes;
      logic [15:0] e_wc;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: bytes of the current word, whether it is being held, handoffs
   logic [7:0]  m_bytes[$];
   logic        m_held = 1'b0;
   logic [15:0] m_wc   = 16'h0000;

   function automatic logic [52:0] model_expect(input logic rst);
      logic [31:0] w;
      logic [2:0]  nb;
      w = '0;
      for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
      nb = m_held ? 3'(m_bytes.size()) : 3'd0;
      return {(!m_held && !rst), m_held, w, nb, m_wc};
   endfunction

   task automatic model_step(input logic rst, input logic iv, input logic [7:0] b,
                             input logic fl, input logic ordy);
      if (rst) begin
         m_bytes.delete();
         m_held = 1'b0;
         m_wc   = 16'h0000;
      end else if (m_held) begin
         if (ordy) begin
            m_held = 1'b0;
            m_bytes.delete();
            m_wc = m_wc + 16'd1;
         end
      end else begin
         if (iv) m_bytes.push_back(b);
         if ((m_bytes.size() == LANES) || (fl && (m_bytes.size() > 0))) m_held = 1'b1;
      end
   endtask

   task automatic compare(input string name, input logic [52:0] act, input logic [52:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ir=%b ov=%b out=%h bytes=%0d wc=%h, want ir=%b ov=%b out=%h bytes=%0d wc=%h",
                  name, act[52], act[51], act[50:19], act[18:16], act[15:0],
                  exp[52], exp[51], exp[50:19], exp[18:16], exp[15:0]);
      end
   endtask

   // Drive one cycle, compare mid-cycle, advance the model at the edge.
   task automatic cycle(input string name, input logic rst, input logic iv, input logic [7:0] b,
                        input logic fl, input logic ordy,
                        input logic use_tbl, input logic [52:0] tbl_exp);
      logic [52:0] exp;
      reset = rst; in_valid = iv; in_byte = b; flush = fl; out_ready = ordy;
      @(negedge clock);
      exp = use_tbl ? tbl_exp : model_expect(rst);
      compare(name, {in_ready, out_valid, out_word, out_bytes, word_count}, exp);
      @(posedge clock);
      model_step(rst, iv, b, fl, ordy);
      #1;
   endtask

   task automatic mcyc(input string name, input logic rst, input logic iv, input logic [7:0] b,
                       input logic fl, input logic ordy);
      cycle(name, rst, iv, b, fl, ordy, 1'b0, '0);
   endtask

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 16'd0};
      tbl[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 16'd0};
      tbl[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000011, 3'd0, 16'd0};
      tbl[3]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00002211, 3'd0, 16'd0};
      tbl[4]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00332211, 3'd0, 16'd0};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4, 16'd0};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211, 3'd4, 16'd0};
      tbl[7]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 16'd1};
      tbl[8]  = '{1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h000000AA, 3'd0, 16'd1};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000BBAA, 3'd0, 16'd1};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 3'd2, 16'd1};
      tbl[11] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 16'd2};
      tbl[12] = '{1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 32'h000000AA, 3'd0, 16'd2};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 3'd2, 16'd2};
      tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 16'd3};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 16'd3};

      reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      for (int i = 0; i < 16; i++) begin
         cycle($sformatf("table[%0d]", i), tbl[i].rst, tbl[i].iv, tbl[i].b, tbl[i].fl, tbl[i].ordy,
               1'b1, {tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_out, tbl[i].e_bytes, tbl[i].e_wc});
      end

      // Held word is stalled while bytes are offered, then handed off
      for (int i = 0; i < 4; i++) mcyc("stall_fill", 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) mcyc("stall_hold", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      mcyc("stall_handoff", 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
      mcyc("first_accept", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      mcyc("lane0_check", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Reset discards a partial word
      mcyc("pre_rst_a", 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
      mcyc("pre_rst_b", 1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);
      mcyc("mid_reset", 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) mcyc("post_rst_fill", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      mcyc("post_rst_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      mcyc("post_rst_hs", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      mcyc("post_rst_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Reset while holding drops the word without counting it
      mcyc("hold_a", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      mcyc("hold_rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      mcyc("after_hold_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Counter wrap: preload the handoff count, then complete one more word
      force dut.word_count_q = 16'hFFFF;
      @(posedge clock);
      #1;
      release dut.word_count_q;
      m_wc = 16'hFFFF;
      mcyc("wrap_pre", 1'b0, 1'b1, 8'h9A, 1'b1, 1'b0);
      mcyc("wrap_hs", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clock);
      compare("wrap_count", {37'd0, word_count}, {37'd0, 16'h0000});
      @(posedge clock);
      #1;

      for (int i = 0; i < 600; i++) begin
         mcyc("random", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
              8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
